// File: rtl/img_pkg.sv
// Shared image-path constants, streamer FSM state encoding and a counter-width helper.
package img_pkg;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned IMG_W_DEF = 9;
    localparam int unsigned IMG_H_DEF = 9;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_READ  = 3'd1;
    localparam state_t ST_GAP   = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // Width needed to count 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_addr_gen.sv
// Raster-order column/row/address counters with end-of-row and last-pixel flags.
module raster_addr_gen
    import img_pkg::*;
#(
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              adv,
    output logic [ADDR_W-1:0] addr,
    output logic              end_of_row_c,
    output logic              last_px_c
);

    localparam int unsigned COL_W = cnt_w(IMG_W);
    localparam int unsigned ROW_W = cnt_w(IMG_H);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    assign end_of_row_c = (col == COL_W'(IMG_W - 1));
    assign last_px_c    = end_of_row_c && (row == ROW_W'(IMG_H - 1));

    // Advancing past the last pixel wraps to the frame origin.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (clr || (adv && last_px_c)) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (adv) begin
            addr <= addr + ADDR_W'(1);
            if (end_of_row_c) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/gray_frame_streamer.sv
// Streams a frame from a synchronous-read buffer as 8-bit pixels with a done strobe.
// STREAMER_FRAME_LOOP_EN: stream frames back-to-back after the first start_i.
module gray_frame_streamer
    import img_pkg::*;
#(
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned H_GAP  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              hold_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [PIX_W-1:0]  mem_data_i,
    output logic [PIX_W-1:0]  grayscale_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    state_t      state;
    state_t      next_state;
    logic [7:0]  gap_cnt;
    logic        rd_c;
    logic        adv_c;
    logic        clr_c;
    logic        rd_d1;
    logic        end_of_row_c;
    logic        last_px_c;

    raster_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr_c),
        .adv          (adv_c),
        .addr         (mem_addr_o),
        .end_of_row_c (end_of_row_c),
        .last_px_c    (last_px_c)
    );

    always_ff @(posedge clk) begin
        if (rst_n) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        rd_c       = 1'b0;
        adv_c      = 1'b0;
        clr_c      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    next_state = ST_READ;
                    clr_c      = 1'b1;
                end
            end
            ST_READ: begin
                if (!hold_i) begin
                    rd_c  = 1'b1;
                    adv_c = 1'b1;
                    if (last_px_c)                      next_state = ST_DRAIN;
                    else if (end_of_row_c && H_GAP != 0) next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == 8'(H_GAP - 1)) next_state = ST_READ;
            end
            ST_DRAIN: next_state = ST_DONE;
            ST_DONE: begin
`ifdef STREAMER_FRAME_LOOP_EN
                next_state = ST_READ;
                clr_c      = 1'b1;
`else
                next_state = ST_IDLE;
`endif
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Blanking length is fixed; hold_i is not looked at while in GAP.
    always_ff @(posedge clk) begin
        if (rst_n)               gap_cnt <= '0;
        else if (state == ST_GAP) gap_cnt <= gap_cnt + 8'(1);
        else                     gap_cnt <= '0;
    end

    assign mem_rd_o = rd_c;

    // Read strobe is delayed to line up with buffer data, then registered once more.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rd_d1        <= 1'b0;
            done_o       <= 1'b0;
            grayscale_o  <= '0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            rd_d1        <= rd_c;
            done_o       <= rd_d1;
            if (rd_d1) grayscale_o <= mem_data_i;
            busy_o       <= (next_state != ST_IDLE);
            frame_done_o <= (state == ST_DONE);
        end
    end

endmodule

// File: tb/tb_gray_frame_streamer.sv
// Directed bench: two streamers (no blanking / 3-cycle blanking) over value=addr buffers.
module tb_gray_frame_streamer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, hold0 = 1'b0, start1 = 1'b0, hold1 = 1'b0;
    logic       rd0, rd1, done0, done1, busy0, busy1, fd0, fd1;
    logic [6:0] addr0, addr1;
    logic [7:0] md0, md1, gs0, gs1;
    logic [7:0] mem [128];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int q0[$], t0[$], f0[$], q1[$], t1[$], f1[$];

    always #5 clk = ~clk;

    gray_frame_streamer #(.IMG_W(9), .IMG_H(9), .ADDR_W(7), .H_GAP(0)) dut0 (
        .clk(clk), .rst_n(rst), .start_i(start0), .hold_i(hold0),
        .mem_rd_o(rd0), .mem_addr_o(addr0), .mem_data_i(md0),
        .grayscale_o(gs0), .done_o(done0), .busy_o(busy0), .frame_done_o(fd0));

    gray_frame_streamer #(.IMG_W(9), .IMG_H(9), .ADDR_W(7), .H_GAP(3)) dut1 (
        .clk(clk), .rst_n(rst), .start_i(start1), .hold_i(hold1),
        .mem_rd_o(rd1), .mem_addr_o(addr1), .mem_data_i(md1),
        .grayscale_o(gs1), .done_o(done1), .busy_o(busy1), .frame_done_o(fd1));

    initial for (int i = 0; i < 128; i++) mem[i] = 8'(i);

    always @(posedge clk) begin
        if (rd0) md0 <= mem[addr0];
        if (rd1) md1 <= mem[addr1];
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (done0) begin q0.push_back(int'(gs0)); t0.push_back(cyc); end
        if (done1) begin q1.push_back(int'(gs1)); t1.push_back(cyc); end
        if (fd0) f0.push_back(cyc);
        if (fd1) f1.push_back(cyc);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_q();
        q0.delete(); t0.delete(); f0.delete();
        q1.delete(); t1.delete(); f1.delete();
    endtask

    task automatic wait_fd(input int which, input int n, input int budget, input string name);
        int sz;
        sz = 0;
        for (int k = 0; k < budget; k++) begin
            sz = (which == 0) ? f0.size() : f1.size();
            if (sz >= n) break;
            step();
        end
        sz = (which == 0) ? f0.size() : f1.size();
        checks++;
        if (sz < n) begin
            errors++;
            $display("FAIL %s timeout: frame_done count %0d expected %0d", name, sz, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++;
        if ({rd0, addr0, gs0, done0, busy0, fd0} !== '0) begin
            errors++;
            $display("FAIL reset_dut0: got %b expected 0", {rd0, addr0, gs0, done0, busy0, fd0});
        end
        checks++;
        if ({rd1, addr1, gs1, done1, busy1, fd1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1: got %b expected 0", {rd1, addr1, gs1, done1, busy1, fd1});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int c0, bad;
        clear_q();
        c0 = cyc;
        start0 = 1'b1; step(); start0 = 1'b0;
        checks++;
        if ({rd0, addr0, busy0} !== {1'b1, 7'd0, 1'b1}) begin
            errors++;
            $display("FAIL basic_first_read: rd/addr/busy got %b expected 1_0000000_1", {rd0, addr0, busy0});
        end
        wait_fd(0, 1, 300, "basic");
        checks++;
        if (q0.size() != 81) begin errors++; $display("FAIL basic_count: got %0d expected 81", q0.size()); end
        bad = 0;
        for (int i = 0; i < q0.size(); i++) if (q0[i] != i) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL basic_order: %0d wrong pixels expected 0", bad); end
        if (q0.size() == 81) begin
            bad = 0;
            for (int i = 0; i < 80; i++) if (t0[i+1] != t0[i] + 1) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL basic_contig: %0d gaps expected 0", bad); end
            checks++;
            if (t0[0] != c0 + 3) begin errors++; $display("FAIL basic_latency: first done at %0d expected %0d", t0[0], c0 + 3); end
            checks++;
            if (f0.size() != 1 || f0[0] != t0[80] + 1) begin
                errors++; $display("FAIL basic_frame_done: at %0d expected %0d", (f0.size() > 0) ? f0[0] : -1, t0[80] + 1);
            end
        end
        checks++;
        if (busy0 !== 1'b0 || fd0 !== 1'b1) begin
            errors++; $display("FAIL basic_busy_end: busy %b fd %b expected busy 0 fd 1", busy0, fd0);
        end
        step();
        checks++;
        if (fd0 !== 1'b0 || done0 !== 1'b0) begin
            errors++; $display("FAIL basic_idle: fd %b done %b expected 0 0", fd0, done0);
        end
    endtask

    task automatic test_gap();
        int bad, ngap, exp_d;
        clear_q();
        start1 = 1'b1; step(); start1 = 1'b0;
        wait_fd(1, 1, 400, "gap");
        checks++;
        if (q1.size() != 81) begin errors++; $display("FAIL gap_count: got %0d expected 81", q1.size()); end
        bad = 0;
        for (int i = 0; i < q1.size(); i++) if (q1[i] != i) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL gap_order: %0d wrong pixels expected 0", bad); end
        if (q1.size() == 81) begin
            bad = 0; ngap = 0;
            for (int i = 0; i < 80; i++) begin
                exp_d = ((i % 9) == 8) ? 4 : 1;
                if (t1[i+1] - t1[i] != exp_d) bad++;
                if (t1[i+1] - t1[i] == 4) ngap++;
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL gap_spacing: %0d wrong spacings expected 0", bad); end
            checks++;
            if (ngap != 8) begin errors++; $display("FAIL gap_total: got %0d gaps expected 8", ngap); end
            checks++;
            if (f1.size() != 1 || f1[0] != t1[80] + 1) begin
                errors++; $display("FAIL gap_frame_done: at %0d expected %0d", (f1.size() > 0) ? f1[0] : -1, t1[80] + 1);
            end
        end
        step();
    endtask

    task automatic test_hold();
        int bad, n6;
        clear_q();
        start0 = 1'b1; step(); start0 = 1'b0;
        for (int k = 0; k < 100 && q0.size() < 20; k++) step();
        hold0 = 1'b1;
        step();
        checks++;
        if (rd0 !== 1'b0) begin errors++; $display("FAIL hold_rd: got %b expected 0", rd0); end
        step(); step(); step(); step();
        hold0 = 1'b0;
        wait_fd(0, 1, 300, "hold");
        checks++;
        if (q0.size() != 81) begin errors++; $display("FAIL hold_count: got %0d expected 81", q0.size()); end
        bad = 0;
        for (int i = 0; i < q0.size(); i++) if (q0[i] != i) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL hold_order: %0d wrong pixels expected 0", bad); end
        if (q0.size() == 81) begin
            bad = 0; n6 = 0;
            for (int i = 0; i < 80; i++) begin
                if (t0[i+1] - t0[i] == 6) n6++;
                else if (t0[i+1] - t0[i] != 1) bad++;
            end
            checks++;
            if (n6 != 1 || bad != 0) begin
                errors++; $display("FAIL hold_pause: %0d six-cycle pauses and %0d other gaps expected 1 and 0", n6, bad);
            end
        end
        step();
    endtask

    task automatic test_reset_mid();
        int n, bad;
        clear_q();
        start0 = 1'b1; step(); start0 = 1'b0;
        for (int k = 0; k < 100 && q0.size() < 40; k++) step();
        rst = 1'b1;
        step();
        checks++;
        if ({done0, gs0, busy0, rd0, fd0} !== '0) begin
            errors++; $display("FAIL midreset_outputs: got %b expected 0", {done0, gs0, busy0, rd0, fd0});
        end
        rst = 1'b0;
        n = q0.size();
        for (int k = 0; k < 10; k++) step();
        checks++;
        if (q0.size() != n || f0.size() != 0) begin
            errors++; $display("FAIL midreset_quiet: extra done %0d frame_done %0d expected 0 0", q0.size() - n, f0.size());
        end
        clear_q();
        start0 = 1'b1; step(); start0 = 1'b0;
        wait_fd(0, 1, 300, "restart");
        bad = 0;
        for (int i = 0; i < q0.size(); i++) if (q0[i] != i) bad++;
        checks++;
        if (q0.size() != 81 || bad != 0) begin
            errors++; $display("FAIL restart_frame: count %0d bad %0d expected 81 0", q0.size(), bad);
        end
        step();
    endtask

    task automatic test_start_busy();
        int bad;
        clear_q();
        start0 = 1'b1; step(); start0 = 1'b0;
        for (int k = 0; k < 30; k++) step();
        start0 = 1'b1; step(); start0 = 1'b0;
        wait_fd(0, 1, 300, "start_busy");
        for (int k = 0; k < 10; k++) step();
        checks++;
        if (f0.size() != 1) begin errors++; $display("FAIL busy_start_fd: got %0d expected 1", f0.size()); end
        bad = 0;
        for (int i = 0; i < q0.size(); i++) if (q0[i] != i) bad++;
        checks++;
        if (q0.size() != 81 || bad != 0) begin
            errors++; $display("FAIL busy_start_frame: count %0d bad %0d expected 81 0", q0.size(), bad);
        end
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL busy_start_idle: got %b expected 0", busy0); end
    endtask

`ifdef STREAMER_FRAME_LOOP_EN
    task automatic test_loop();
        int bad;
        clear_q();
        start0 = 1'b1; step(); start0 = 1'b0;
        wait_fd(0, 3, 1000, "loop");
        checks++;
        if (q0.size() < 243) begin errors++; $display("FAIL loop_count: got %0d expected >= 243", q0.size()); end
        if (q0.size() >= 243 && f0.size() >= 3) begin
            bad = 0;
            for (int i = 0; i < 243; i++) if (q0[i] != i % 81) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL loop_order: %0d wrong pixels expected 0", bad); end
            bad = 0;
            for (int k = 0; k < 3; k++) if (f0[k] != t0[81*k+80] + 1) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL loop_frame_done: %0d misplaced expected 0", bad); end
            bad = 0;
            for (int k = 0; k < 2; k++) if (t0[81*k+81] - t0[81*k+80] != 3) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL loop_bubble: %0d wrong inter-frame gaps expected 0", bad); end
        end
        checks++;
        if (busy0 !== 1'b1) begin errors++; $display("FAIL loop_busy: got %b expected 1", busy0); end
        rst = 1'b1; step(); rst = 1'b0; step();
    endtask
`endif

    initial begin
        test_reset();
`ifdef STREAMER_FRAME_LOOP_EN
        test_loop();
`else
        test_basic();
        test_gap();
        test_hold();
        test_reset_mid();
        test_start_busy();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
